// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, FSM states and helpers shared by the multicycle ALU
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_DIV = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_REM = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Divide/remainder by zero takes the single-cycle path, so only a
    // multiply or a real division needs the iterative unit.
    function automatic logic is_iter_op(input logic [ALU_OP_W-1:0] op,
                                        input logic                b_is_zero);
        return (op == ALU_MUL) || (((op == ALU_DIV) || (op == ALU_REM)) && !b_is_zero);
    endfunction

    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - iterative unsigned shift-add multiplier and restoring divider
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load operands and start WIDTH iterations
//   i_div          : 1 = divide (A / B), 0 = multiply (A * B)
//   i_a, i_b       : operands, sampled on i_load
//   o_last         : high during the final iteration cycle
//   o_lo           : product low half / quotient
//   o_hi           : product high half / remainder
module alu_iter_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;   // {hi, lo}: {partial product, multiplier} or {remainder, quotient}
    logic [WIDTH-1:0]   r_m;     // multiplicand or divisor
    logic               r_div;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;

    // Multiply: add the multiplicand into the high half when the multiplier
    // LSB is set, then shift the whole accumulator right, keeping the carry.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the remainder and keep the
    // trial subtraction only if it did not go negative.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_m};
    assign w_div_next  = w_div_trial[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_m   <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_cnt <= CNT_LOAD;
            r_acc <= {{WIDTH{1'b0}}, (i_div ? i_a : i_b)};
            r_m   <= i_div ? i_b : i_a;
            r_div <= i_div;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
            r_acc <= r_div ? w_div_next : w_mul_next;
        end
    end

    assign o_last = (r_cnt == CNT_ONE);
    assign o_lo   = r_acc[WIDTH-1:0];
    assign o_hi   = r_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multicycle ALU with registered results/flags and start/done handshake
//
// Ports:
//   input_clk, input_rst_n        : clock, asynchronous active-low reset
//   input_start                   : begin operation when output_Ready=1
//   input_A, input_B, input_ALUOp : operands and opcode, sampled on accepted start
//   output_Ready                  : idle, start will be accepted
//   output_Done                   : one-cycle pulse, results/flags updated
//   output_ALU, output_ALUHi      : primary result, high half / remainder
//   output_Zero/Negative/Carry/Overflow/DivZero/Invalid : status flags
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                input_clk,
    input  logic                input_rst_n,
    input  logic                input_start,
    input  logic [WIDTH-1:0]    input_A,
    input  logic [WIDTH-1:0]    input_B,
    input  logic [ALU_OP_W-1:0] input_ALUOp,
    output logic                output_Ready,
    output logic                output_Done,
    output logic [WIDTH-1:0]    output_ALU,
    output logic [WIDTH-1:0]    output_ALUHi,
    output logic                output_Zero,
    output logic                output_Negative,
    output logic                output_Carry,
    output logic                output_Overflow,
    output logic                output_DivZero,
    output logic                output_Invalid
);

    localparam int SHAMT_W = $clog2(WIDTH);

    alu_state_t          r_state;
    alu_state_t          w_next_state;
    logic                w_accept;
    logic                w_load_iter;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [ALU_OP_W-1:0] r_op;

    logic                r_ready;
    logic                r_done;
    logic [WIDTH-1:0]    r_alu;
    logic [WIDTH-1:0]    r_alu_hi;
    logic                r_zero;
    logic                r_negative;
    logic                r_carry;
    logic                r_overflow;
    logic                r_div_zero;
    logic                r_invalid;

    logic                w_iter_last;
    logic [WIDTH-1:0]    w_iter_lo;
    logic [WIDTH-1:0]    w_iter_hi;

    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [SHAMT_W-1:0]  w_shamt;
    logic                w_b_zero;

    logic [WIDTH-1:0]    w_alu;
    logic [WIDTH-1:0]    w_alu_hi;
    logic                w_carry;
    logic                w_overflow;
    logic                w_div_zero;
    logic                w_invalid;

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .i_clk   (input_clk),
        .i_rst_n (input_rst_n),
        .i_load  (w_load_iter),
        .i_div   (is_div_op(input_ALUOp)),
        .i_a     (input_A),
        .i_b     (input_B),
        .o_last  (w_iter_last),
        .o_lo    (w_iter_lo),
        .o_hi    (w_iter_hi)
    );

    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load_iter  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ready && input_start) begin
                    w_accept = 1'b1;
                    if (is_iter_op(input_ALUOp, (input_B == '0))) begin
                        w_load_iter  = 1'b1;
                        w_next_state = ST_ITER;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_ITER: begin
                if (w_iter_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand capture: later input changes never reach the result.
    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
        end else if (w_accept) begin
            r_a  <= input_A;
            r_b  <= input_B;
            r_op <= input_ALUOp;
        end
    end

    // Both sums carry an extra MSB: carry-out for ADD, borrow for SUB.
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff   = {1'b0, r_a} - {1'b0, r_b};
    assign w_shamt  = r_b[SHAMT_W-1:0];
    assign w_b_zero = (r_b == '0);

    always_comb begin
        w_alu      = '0;
        w_alu_hi   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        w_div_zero = 1'b0;
        w_invalid  = 1'b0;
        case (r_op)
            ALU_ADD: begin
                w_alu      = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_alu      = w_diff[WIDTH-1:0];
                w_carry    = w_diff[WIDTH];
                w_overflow = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            ALU_AND: w_alu = r_a & r_b;
            ALU_OR:  w_alu = r_a | r_b;
            ALU_XOR: w_alu = r_a ^ r_b;
            ALU_SLL: w_alu = r_a << w_shamt;
            ALU_SRL: w_alu = r_a >> w_shamt;
            ALU_SRA: w_alu = WIDTH'($signed(r_a) >>> w_shamt);
            ALU_MUL: begin
                w_alu    = w_iter_lo;
                w_alu_hi = w_iter_hi;
                w_carry  = (w_iter_hi != '0);
            end
            ALU_DIV: begin
                if (w_b_zero) begin
                    w_alu      = '1;
                    w_alu_hi   = r_a;
                    w_div_zero = 1'b1;
                end else begin
                    w_alu    = w_iter_lo;
                    w_alu_hi = w_iter_hi;
                end
            end
            ALU_REM: begin
                if (w_b_zero) begin
                    w_alu      = r_a;
                    w_div_zero = 1'b1;
                end else begin
                    w_alu = w_iter_hi;
                end
            end
            default: begin
                w_invalid = 1'b1;
            end
        endcase
    end

    // Results update only on leaving DONE and hold until the next one.
    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_alu      <= '0;
            r_alu_hi   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_div_zero <= 1'b0;
            r_invalid  <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_accept) begin
                r_ready <= 1'b0;
            end else if (r_state == ST_DONE) begin
                r_ready <= 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_alu      <= w_alu;
                r_alu_hi   <= w_alu_hi;
                r_zero     <= (w_alu == '0);
                r_negative <= w_alu[WIDTH-1];
                r_carry    <= w_carry;
                r_overflow <= w_overflow;
                r_div_zero <= w_div_zero;
                r_invalid  <= w_invalid;
            end
        end
    end

    assign output_Ready    = r_ready;
    assign output_Done     = r_done;
    assign output_ALU      = r_alu;
    assign output_ALUHi    = r_alu_hi;
    assign output_Zero     = r_zero;
    assign output_Negative = r_negative;
    assign output_Carry    = r_carry;
    assign output_Overflow = r_overflow;
    assign output_DivZero  = r_div_zero;
    assign output_Invalid  = r_invalid;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - scoreboard testbench for multicycle_alu
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  op = '0;

    logic        ready, done, zero, neg, carry, ovf, dz, inv;
    logic [15:0] alu, alu_hi;

    multicycle_alu #(.WIDTH(16)) dut (
        .input_clk       (clk),
        .input_rst_n     (rst_n),
        .input_start     (start),
        .input_A         (a),
        .input_B         (b),
        .input_ALUOp     (op),
        .output_Ready    (ready),
        .output_Done     (done),
        .output_ALU      (alu),
        .output_ALUHi    (alu_hi),
        .output_Zero     (zero),
        .output_Negative (neg),
        .output_Carry    (carry),
        .output_Overflow (ovf),
        .output_DivZero  (dz),
        .output_Invalid  (inv)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] alu;
        logic [15:0] hi;
        logic [5:0]  flags;   // {zero, negative, carry, overflow, divzero, invalid}
        int          lat;
        int          issue;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;
    int   ndone = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endfunction

    // Monitor: pops the oldest expectation whenever Done is seen.
    exp_t m;
    always @(negedge clk) begin
        if (done) begin
            ndone++;
            if (q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_done: got Done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                m = q.pop_front();
                check({m.name, ".alu"},     32'(alu),    32'(m.alu));
                check({m.name, ".alu_hi"},  32'(alu_hi), 32'(m.hi));
                check({m.name, ".flags"},   32'({zero, neg, carry, ovf, dz, inv}), 32'(m.flags));
                check({m.name, ".ready"},   32'(ready),  32'd1);
                check({m.name, ".latency"}, 32'(cyc - m.issue - 1), 32'(m.lat));
            end
        end
    end

    // Called at a negedge; returns 1 ns after the accepting posedge.
    task automatic issue(input string nm, input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] ea, input logic [15:0] eh, input logic [5:0] ef, input int lat);
        exp_t e;
        check({nm, ".ready_at_issue"}, 32'(ready), 32'd1);
        e.name = nm; e.alu = ea; e.hi = eh; e.flags = ef; e.lat = lat; e.issue = cyc;
        q.push_back(e);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        op = 4'($urandom);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((q.size() != 0 || !ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            nchk++;
            nfail++;
            $display("FAIL %s.timeout: got %0d pending ops expected 0 within 200 cycles", nm, q.size());
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 200);
        if (!done) begin
            nchk++;
            nfail++;
            $display("FAIL %s.done_timeout: got Done=0 expected Done=1 within 200 cycles", nm);
        end
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.ready", 32'(ready), 32'd1);
        check("reset.done",  32'(done),  32'd0);
        check("reset.alu",   32'(alu),   32'd0);
        check("reset.hi",    32'(alu_hi), 32'd0);
        check("reset.flags", 32'({zero, neg, carry, ovf, dz, inv}), 32'd0);

        issue("add_ovf",  4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 6'b010100, 1);  wait_idle("add_ovf");
        issue("add_carry",4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 6'b101000, 1);  wait_idle("add_carry");
        issue("sub_borrow",4'd1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 6'b011000, 1);  wait_idle("sub_borrow");
        issue("sub_zero", 4'd1,  16'h1234, 16'h1234, 16'h0000, 16'h0000, 6'b100000, 1);  wait_idle("sub_zero");
        issue("and",      4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 6'b000000, 1);  wait_idle("and");
        issue("or",       4'd3,  16'hF0F0, 16'h0FF0, 16'hFFF0, 16'h0000, 6'b010000, 1);  wait_idle("or");
        issue("xor",      4'd4,  16'hF0F0, 16'h0FF0, 16'hFF00, 16'h0000, 6'b010000, 1);  wait_idle("xor");
        issue("sra",      4'd7,  16'h8000, 16'h0004, 16'hF800, 16'h0000, 6'b010000, 1);  wait_idle("sra");
        issue("srl",      4'd6,  16'h8000, 16'h001F, 16'h0001, 16'h0000, 6'b000000, 1);  wait_idle("srl");
        issue("sll",      4'd5,  16'h0001, 16'h0013, 16'h0008, 16'h0000, 6'b000000, 1);  wait_idle("sll");
        repeat (3) @(negedge clk);
        check("hold.alu", 32'(alu), 32'h0008);
        issue("invalid",  4'd12, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 6'b100001, 1);  wait_idle("invalid");

        issue("mul",      4'd8,  16'h1234, 16'h0100, 16'h3400, 16'h0012, 6'b001000, 17);
        repeat (3) @(negedge clk);
        check("mul.busy_ready", 32'(ready), 32'd0);
        op = 4'd0; a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("mul");

        issue("div",      4'd9,  16'd100,  16'd7,    16'h000E, 16'h0002, 6'b000000, 17); wait_idle("div");
        issue("rem",      4'd10, 16'd100,  16'd7,    16'h0002, 16'h0000, 6'b000000, 17); wait_idle("rem");
        issue("div0",     4'd9,  16'h0042, 16'h0000, 16'hFFFF, 16'h0042, 6'b010010, 1);  wait_idle("div0");
        issue("rem0",     4'd10, 16'h0055, 16'h0000, 16'h0055, 16'h0000, 6'b000010, 1);  wait_idle("rem0");

        // Abandon a multiply with an asynchronous reset in its 5th iteration.
        d0 = ndone;
        op = 4'd8; a = 16'h1234; b = 16'h5678; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid.ready", 32'(ready), 32'd1);
        check("rst_mid.done",  32'(done),  32'd0);
        check("rst_mid.alu",   32'(alu),   32'd0);
        check("rst_mid.hi",    32'(alu_hi), 32'd0);
        check("rst_mid.flags", 32'({zero, neg, carry, ovf, dz, inv}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("rst_mid.no_done", 32'(ndone - d0), 32'd0);
        check("rst_mid.ready_after", 32'(ready), 32'd1);

        // Back-to-back: each next start goes in during the previous Done cycle.
        issue("b2b_add", 4'd0, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 6'b000000, 1);
        wait_done("b2b_add");
        issue("b2b_mul", 4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 6'b001000, 17);
        wait_done("b2b_mul");
        issue("b2b_sub", 4'd1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 6'b000100, 1);
        wait_idle("b2b_sub");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1000000 ns");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised successor to the processor's single-cycle 16-bit ALU.
- Adds registered results and flags, carry and overflow flags, shifts, and iterative unsigned multiply, divide and remainder.
- Uses a start/done handshake.
- Sits in the datapath between the A/B operand registers and the ALUOut register; the control FSM issues start and waits for done.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of two)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from input_B (derived, not overridden)

Ports:
input_clk  input  1  system clock, rising edge
input_rst_n  input  1  asynchronous active-low reset
input_start  input  1  begin operation; accepted only when output_Ready=1
input_A  input  WIDTH  operand A, sampled on accepted start
input_B  input  WIDTH  operand B, sampled on accepted start
input_ALUOp  input  4  operation code, sampled on accepted start
output_Ready  output  1  idle, can accept start
output_Done  output  1  one-cycle pulse: results/flags valid and updated
output_ALU  output  WIDTH  primary result (sum, difference, logic, shift, product low half, quotient, remainder)
output_ALUHi  output  WIDTH  product high half (MUL), remainder (DIV), else 0
output_Zero  output  1  output_ALU == 0
output_Negative  output  1  output_ALU[WIDTH-1]
output_Carry  output  1  ADD carry-out; SUB borrow (A<B unsigned); MUL high half nonzero; else 0
output_Overflow  output  1  signed overflow for ADD/SUB; else 0
output_DivZero  output  1  DIV/REM with B==0
output_Invalid  output  1  opcode 11-15

Behaviour:
- Clock and reset: one clock, input_clk. input_rst_n is asynchronous active-low.
- Reset state: FSM goes to IDLE and every output register clears to 0, except output_Ready, which is 1.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[SHAMT_W-1:0], upper bits ignored
  - 8 MUL, 9 DIV, 10 REM; all unsigned
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - On input_start, latch A, B and opcode, and drop output_Ready.
  - Ops 0-7, invalid opcodes and divide-by-zero go to DONE; the result is computed combinationally from the latched operands.
  - MUL and DIV/REM with B!=0 go to ITER with the counter at WIDTH.
- ITER:
  - MUL: shift-add, one multiplier bit per cycle, with a 2*WIDTH accumulator.
  - DIV/REM: restoring division, one quotient bit per cycle.
  - The counter decrements each cycle; the last iteration goes to DONE.
- DONE:
  - Register result and flags, pulse output_Done for exactly 1 cycle, set output_Ready=1, return to IDLE.
- Latency, counted as the number of cycles from the start edge to the Done-high cycle:
  - single-cycle ops: 1
  - MUL, DIV, REM: WIDTH+1
- output_Ready rises in the same cycle as output_Done. A start in that cycle is accepted, which allows back-to-back operation.
- input_start while output_Ready=0 is ignored; there is no queueing.
- Results and flags hold their values between Done pulses. Input changes after acceptance have no effect.
- Divide by zero, via the DIV/REM fast path:
  - output_ALU = all-ones for DIV, A for REM.
  - output_ALUHi = A for DIV.
  - DivZero=1.
- Invalid opcode: result 0, Invalid=1, Zero=1.
- Flags are computed from the final output_ALU; flags not applicable to the op are 0.
- Reset asserted mid-ITER: the operation is abandoned, no Done is issued, and outputs return to reset values.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams: ALU_ADD .. ALU_REM, ALU_OP_W=4
  - FSM state encoding
- One natural sub-module: alu_iter_muldiv. It holds the iterative accumulator, shift register and counter, and gives the top a start/last-cycle interface.
- Combinational ops, flags and the FSM stay in the top.

Test Plan (WIDTH=16):
- ADD 0x7FFF+0x0001 -> ALU=0x8000, Negative=1, Overflow=1, Carry=0, Zero=0; Done 1 cycle after start.
- SUB 0x0003-0x0005 -> ALU=0xFFFE, Carry(borrow)=1, Negative=1. SUB 0x1234-0x1234 -> Zero=1, Carry=0.
- MUL 0x1234*0x0100 -> ALU=0x3400, ALUHi=0x0012, Carry=1; Done exactly 17 cycles after start. A second start pulsed mid-operation is ignored.
- DIV 100/7 -> ALU=0x000E, ALUHi=0x0002. REM 100/7 -> ALU=0x0002. DIV 0x0042/0 -> ALU=0xFFFF, ALUHi=0x0042, DivZero=1, latency 1.
- Shifts and invalid opcode:
  - SRA 0x8000 by 4 -> 0xF800.
  - SLL 0x0001 with B=0x0013 -> 0x0008 (shift 3).
  - Opcode 12 -> ALU=0, Invalid=1.
- Reset:
  - Assert input_rst_n low asynchronously during ITER cycle 5 of MUL -> no Done pulse, Ready=1, all results 0.
  - After release, a back-to-back ADD, MUL sequence completes with correct values, including a start issued in the Done cycle.
